// File: rtl/ahb2regbus_pkg.sv
// Shared AHB-Lite constants and the bridge state encoding. Stands in for ahb_defines.vh.
// AHB2REGBUS_ERR_RESP_EN adds the two-cycle ERROR states.
package ahb2regbus_pkg;
  localparam int AHB_DATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
`ifdef AHB2REGBUS_ERR_RESP_EN
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5,
`endif
    ST_RD_DONE = 3'd3
  } state_t;

  function automatic logic htrans_active(input logic [1:0] trans);
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/ahb2regbus_qual.sv
// Combinational AHB-Lite address-phase qualification: accept, legality and direction.
module ahb2regbus_qual
  import ahb2regbus_pkg::*;
(
  input  logic       sel,
  input  logic       ready,
  input  logic [1:0] trans,
  input  logic [2:0] size,
  input  logic [1:0] addr_lsb,
  input  logic       write,
  output logic       accept,
  output logic       legal,
  output logic       is_write
);
  assign accept   = sel & ready & htrans_active(trans);
  assign legal    = (size == HSIZE_WORD) && (addr_lsb == 2'b00);
  assign is_write = write;
endmodule

// File: rtl/ahb2regbus.sv
// AHB-Lite slave to single-cycle register-bus bridge (one wait state on reads).
// Optional AHB2REGBUS_ERR_RESP_EN: two-cycle ERROR response for non-word/misaligned transfers.
module ahb2regbus
  import ahb2regbus_pkg::*;
(
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [AHB_DATA_WIDTH-1:0] HRDATA,
  output logic                      valid_reg_access,
  output logic [15:0]               addr,
  output logic                      rd_wr,
  output logic [AHB_DATA_WIDTH-1:0] write_data,
  input  logic [AHB_DATA_WIDTH-1:0] read_data
);
  state_t                    state_reg, state_next;
  logic [15:0]               addr_reg;
  logic [AHB_DATA_WIDTH-1:0] hrdata_reg;
  logic                      accept, legal, is_write, take;
  logic                      unused_haddr;

  assign unused_haddr = &{1'b0, HADDR[31:16]};

  ahb2regbus_qual u_qual (
    .sel      (HSEL),
    .ready    (HREADY),
    .trans    (HTRANS),
    .size     (HSIZE),
    .addr_lsb (HADDR[1:0]),
    .write    (HWRITE),
    .accept   (accept),
    .legal    (legal),
    .is_write (is_write)
  );

  // Only take a new address phase while our own data phase is ending.
  assign take = accept & HREADYOUT;

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_RD: state_next = ST_RD_DONE;
`ifdef AHB2REGBUS_ERR_RESP_EN
      ST_ERR1: state_next = ST_ERR2;
`endif
      default: begin
        if (take) begin
          if (legal)
            state_next = is_write ? ST_WR : ST_RD;
          else
`ifdef AHB2REGBUS_ERR_RESP_EN
            state_next = ST_ERR1;
`else
            state_next = ST_IDLE;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      hrdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take)
        addr_reg <= HADDR[15:0];
      if (state_reg == ST_RD)
        hrdata_reg <= read_data;
`ifndef AHB2REGBUS_ERR_RESP_EN
      // Illegal reads complete as OKAY with zero data.
      if (take && !legal && !is_write)
        hrdata_reg <= '0;
`endif
    end
  end

  assign valid_reg_access = (state_reg == ST_WR) || (state_reg == ST_RD);
  assign rd_wr            = (state_reg == ST_WR);
  assign write_data       = (state_reg == ST_WR) ? HWDATA : '0;
  assign addr             = addr_reg;
  assign HRDATA           = hrdata_reg;

`ifdef AHB2REGBUS_ERR_RESP_EN
  assign HRESP     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HREADYOUT = !((state_reg == ST_RD) || (state_reg == ST_ERR1));
`else
  assign HRESP     = HRESP_OKAY;
  assign HREADYOUT = (state_reg != ST_RD);
`endif
endmodule

// File: tb/tb_ahb2regbus.sv
// Directed self-checking bench for ahb2regbus with a four-word register-bus model.
// Expectations follow AHB2REGBUS_ERR_RESP_EN when it is defined.
module tb_ahb2regbus;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic        valid_reg_access, rd_wr;
  logic [15:0] addr;
  logic [31:0] write_data, read_data;

  logic [31:0] regs [4];
  int          strobe_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 HCLK = ~HCLK;

  // Single slave on the bus: bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  ahb2regbus dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .HSEL             (HSEL),
    .HADDR            (HADDR),
    .HTRANS           (HTRANS),
    .HSIZE            (HSIZE),
    .HWRITE           (HWRITE),
    .HWDATA           (HWDATA),
    .HREADY           (HREADY),
    .HREADYOUT        (HREADYOUT),
    .HRESP            (HRESP),
    .HRDATA           (HRDATA),
    .valid_reg_access (valid_reg_access),
    .addr             (addr),
    .rd_wr            (rd_wr),
    .write_data       (write_data),
    .read_data        (read_data)
  );

  assign read_data = (valid_reg_access && !rd_wr) ? regs[addr[3:2]] : 32'h0;

  always @(posedge HCLK) begin
    if (valid_reg_access) begin
      strobe_cnt <= strobe_cnt + 1;
      if (rd_wr)
        regs[addr[3:2]] <= write_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = a;
    HWRITE = wr;
    HSIZE = sz;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    regs[0] = 32'h0000_1234;
    regs[1] = 32'h0000_5678;
    regs[2] = 32'h0;
    regs[3] = 32'h0;

    // Reset state
    #12;
    check_val("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("rst_hresp", {31'b0, HRESP}, 32'd0);
    check_val("rst_hrdata", HRDATA, 32'h0);
    check_val("rst_valid", {31'b0, valid_reg_access}, 32'd0);
    check_val("rst_addr", {16'b0, addr}, 32'h0);
    check_val("rst_wdata", write_data, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single write
    next_cycle();
    addr_phase(32'h0000_0008, 1'b1, 3'b010);
    next_cycle();
    bus_idle();
    HWDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    check_val("wr_valid", {31'b0, valid_reg_access}, 32'd1);
    check_val("wr_rd_wr", {31'b0, rd_wr}, 32'd1);
    check_val("wr_addr", {16'b0, addr}, 32'h8);
    check_val("wr_wdata", write_data, 32'hDEAD_BEEF);
    check_val("wr_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("wr_hresp", {31'b0, HRESP}, 32'd0);
    next_cycle();
    check_val("wr_reg_updated", regs[2], 32'hDEAD_BEEF);
    check_val("wr_strobe_gone", {31'b0, valid_reg_access}, 32'd0);
    $display("txn write addr=0008 data=deadbeef");

    // Single read
    addr_phase(32'h0000_0000, 1'b0, 3'b010);
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    check_val("rd_t1_hreadyout", {31'b0, HREADYOUT}, 32'd0);
    check_val("rd_t1_valid", {31'b0, valid_reg_access}, 32'd1);
    check_val("rd_t1_rd_wr", {31'b0, rd_wr}, 32'd0);
    check_val("rd_t1_wdata", write_data, 32'h0);
    next_cycle();
    @(negedge HCLK);
    check_val("rd_t2_hrdata", HRDATA, 32'h0000_1234);
    check_val("rd_t2_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("rd_t2_valid", {31'b0, valid_reg_access}, 32'd0);
    $display("txn read addr=0000 data=%h", HRDATA);

    // Back-to-back: write 8, write C, read 8
    next_cycle();
    cnt0 = strobe_cnt;
    addr_phase(32'h0000_0008, 1'b1, 3'b010);
    next_cycle();
    HWDATA = 32'h1111_00A1;
    addr_phase(32'h0000_000C, 1'b1, 3'b010);
    @(negedge HCLK);
    check_val("b2b_t1_addr", {16'b0, addr}, 32'h8);
    check_val("b2b_t1_wdata", write_data, 32'h1111_00A1);
    next_cycle();
    HWDATA = 32'h2222_00A2;
    addr_phase(32'h0000_0008, 1'b0, 3'b010);
    @(negedge HCLK);
    check_val("b2b_t2_valid", {31'b0, valid_reg_access}, 32'd1);
    check_val("b2b_t2_addr", {16'b0, addr}, 32'hC);
    check_val("b2b_t2_wdata", write_data, 32'h2222_00A2);
    next_cycle();
    bus_idle();
    HWDATA = 32'h0;
    @(negedge HCLK);
    check_val("b2b_t3_valid", {31'b0, valid_reg_access}, 32'd1);
    check_val("b2b_t3_rd_wr", {31'b0, rd_wr}, 32'd0);
    check_val("b2b_t3_addr", {16'b0, addr}, 32'h8);
    check_val("b2b_t3_hreadyout", {31'b0, HREADYOUT}, 32'd0);
    next_cycle();
    @(negedge HCLK);
    check_val("b2b_t4_hrdata", HRDATA, 32'h1111_00A1);
    check_val("b2b_t4_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("b2b_reg_c", regs[3], 32'h2222_00A2);
    next_cycle();
    check_val("b2b_strobes", strobe_cnt - cnt0, 32'd3);
    $display("txn b2b wr 0008, wr 000c, rd 0008 data=%h", HRDATA);

    // Byte write to 0x0009
    cnt0 = strobe_cnt;
    addr_phase(32'h0000_0009, 1'b1, 3'b000);
    next_cycle();
    bus_idle();
    HWDATA = 32'h0000_00FF;
    @(negedge HCLK);
    check_val("bw_t1_valid", {31'b0, valid_reg_access}, 32'd0);
`ifdef AHB2REGBUS_ERR_RESP_EN
    check_val("bw_t1_hresp", {31'b0, HRESP}, 32'd1);
    check_val("bw_t1_hreadyout", {31'b0, HREADYOUT}, 32'd0);
    next_cycle();
    @(negedge HCLK);
    check_val("bw_t2_hresp", {31'b0, HRESP}, 32'd1);
    check_val("bw_t2_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("bw_t2_valid", {31'b0, valid_reg_access}, 32'd0);
`else
    check_val("bw_t1_hresp", {31'b0, HRESP}, 32'd0);
    check_val("bw_t1_hreadyout", {31'b0, HREADYOUT}, 32'd1);
`endif
    next_cycle();
    HWDATA = 32'h0;
    check_val("bw_strobes", strobe_cnt - cnt0, 32'd0);
    $display("txn byte write addr=0009 hresp=%0b", HRESP);

    // Misaligned word read to 0x0002
    addr_phase(32'h0000_0002, 1'b0, 3'b010);
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    check_val("mr_t1_valid", {31'b0, valid_reg_access}, 32'd0);
`ifdef AHB2REGBUS_ERR_RESP_EN
    check_val("mr_t1_hresp", {31'b0, HRESP}, 32'd1);
    check_val("mr_t1_hreadyout", {31'b0, HREADYOUT}, 32'd0);
    next_cycle();
`else
    check_val("mr_t1_hresp", {31'b0, HRESP}, 32'd0);
    check_val("mr_t1_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("mr_t1_hrdata", HRDATA, 32'h0);
`endif
    next_cycle();
    $display("txn misaligned read addr=0002");

    // IDLE transfer with HSEL=1
    cnt0 = strobe_cnt;
    HSEL = 1'b1;
    HTRANS = 2'b00;
    HADDR = 32'h0000_0004;
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    check_val("idle_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("idle_hresp", {31'b0, HRESP}, 32'd0);
    check_val("idle_valid", {31'b0, valid_reg_access}, 32'd0);
    next_cycle();
    check_val("idle_strobes", strobe_cnt - cnt0, 32'd0);
    $display("txn idle htrans with hsel=1");

    // Reset asserted during RD
    addr_phase(32'h0000_0004, 1'b0, 3'b010);
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    check_val("rr_in_rd", {31'b0, HREADYOUT}, 32'd0);
    cnt0 = strobe_cnt;
    HRESETn = 1'b0;
    #1;
    check_val("rr_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_val("rr_hrdata", HRDATA, 32'h0);
    check_val("rr_valid", {31'b0, valid_reg_access}, 32'd0);
    check_val("rr_addr", {16'b0, addr}, 32'h0);
    next_cycle();
    check_val("rr_no_strobe", strobe_cnt - cnt0, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    next_cycle();
    addr_phase(32'h0000_0004, 1'b0, 3'b010);
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    check_val("rr_post_valid", {31'b0, valid_reg_access}, 32'd1);
    check_val("rr_post_addr", {16'b0, addr}, 32'h4);
    next_cycle();
    @(negedge HCLK);
    check_val("rr_post_hrdata", HRDATA, 32'h0000_5678);
    check_val("rr_post_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    $display("txn reset during read, then read addr=0004 data=%h", HRDATA);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb2regbus.md
# ahb2regbus

AHB-Lite slave-side bridge that converts single AHB transfers into the simple register-bus handshake (`valid_reg_access`, `addr`, `rd_wr`, `write_data`, `read_data`) used by peripheral register blocks such as the core timer. It sits between the AHB interconnect's slave port and one register block. It owns the AHB data-phase timing, wait states, the read-data register and the error response; the register block stays purely single-cycle.

## Interface
- `AHB_DATA_WIDTH`, 32 (from `ahb_defines.vh`), AHB and register data width.
- `HCLK` in 1: AHB clock. Single clock domain.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HSEL` in 1: slave select.
- `HADDR` in 32: transfer address. Only `[15:0]` is forwarded.
- `HTRANS` in 2: transfer type.
- `HSIZE` in 3: transfer size.
- `HWRITE` in 1: 1 = write.
- `HWDATA` in 32: write data (data phase).
- `HREADY` in 1: bus-level ready (previous data phase ends).
- `HREADYOUT` out 1: this slave's ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `HRDATA` out 32: read data, registered.
- `valid_reg_access` out 1: one-cycle register access strobe.
- `addr` out 16: register address, registered.
- `rd_wr` out 1: 1 = write, 0 = read.
- `write_data` out 32: register write data.
- `read_data` in 32: combinational register read data. Valid in the same cycle as `valid_reg_access` with `rd_wr = 0`.

## Operation
- Accept condition: `HSEL & HREADY & HTRANS[1]` (NONSEQ/SEQ). On accept, register `HADDR[15:0]`, `HWRITE` and the legality check.
- IDLE/BUSY transfers and unselected cycles: no regbus access; zero-wait OKAY.
- States and transitions:
  - IDLE: on a legal accepted write go to WR; legal read go to RD; illegal transfer go to ERR1.
  - WR: `valid_reg_access=1`, `rd_wr=1`, `write_data=HWDATA`, `HREADYOUT=1`. Next state follows the accept logic; no accept returns to IDLE.
  - RD: `valid_reg_access=1`, `rd_wr=0`, `HREADYOUT=0`. Capture `read_data` into `HRDATA`. Always go to RD_DONE.
  - RD_DONE: `HREADYOUT=1`, `HRDATA` valid. Next state follows the accept logic.
  - ERR1: `HRESP=1`, `HREADYOUT=0`. Always go to ERR2.
  - ERR2: `HRESP=1`, `HREADYOUT=1`. Next state follows the accept logic.
- Legal transfer: `HSIZE` = word (3'b010) and `HADDR[1:0]` = 0.
- `write_data` is 0 outside WR. `valid_reg_access` is never high outside WR or RD.
- `HRDATA` holds its last value until the next read capture.
- `addr` holds its value between accesses.

## Timing
- Reset values: `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, `valid_reg_access=0`, `addr=0`, `rd_wr=0`, `write_data=0`, state IDLE.
- Write, address phase at T0: the register strobe is in T1 and the register updates at the end of T1. Zero wait states.
- Read, address phase at T0:
  - T1: strobe issued, `HREADYOUT=0`.
  - T2: `HRDATA` valid, `HREADYOUT=1`.
  - One wait state.
- Error, address phase at T0: T1 is `HRESP=1` with `HREADYOUT=0`; T2 is `HRESP=1` with `HREADYOUT=1`. No regbus strobe.
- Back-to-back transfers:
  - A new address phase is accepted in WR, RD_DONE, ERR2 or IDLE when `HREADY=1`.
  - Write after write: strobes in consecutive cycles.
  - Read then write: write strobe in T3.
- No accept is possible in RD or ERR1, because `HREADY` is low there.
- Reset asserted mid-transfer: all outputs take their reset values immediately (async). The in-flight access is dropped; no partial strobe.

## Configuration
- `AHB2REGBUS_ERR_RESP_EN` defined: illegal transfers (non-word or misaligned) get the two-cycle ERROR response above.
- `AHB2REGBUS_ERR_RESP_EN` undefined:
  - ERR1/ERR2 are not built.
  - Illegal transfers complete as zero-wait OKAY with no regbus strobe.
  - An illegal read returns `HRDATA = 0`.

## Structure
- `ahb_defines.vh` holds:
  - `AHB_DATA_WIDTH`.
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP codes (OKAY/ERROR).
  - `HSIZE_WORD`.
- State encodings are local parameters.
- One sub-module: `ahb2regbus_qual`. It is combinational accept/legality qualification (`accept`, `legal`, `is_write`), reused by future AHB slaves.

## Test plan
- Write 32'hDEAD_BEEF to 0x0008 (word) -> T1: `valid_reg_access=1`, `rd_wr=1`, `addr=16'h0008`, `write_data=32'hDEADBEEF`; `HREADYOUT=1`, `HRESP=0`.
- Read 0x0000 with the regbus model returning 32'h0000_1234 -> T1: `HREADYOUT=0`, strobe with `rd_wr=0`; T2: `HRDATA=32'h00001234`, `HREADYOUT=1`.
- Back-to-back write 0x0008, write 0x000C, read 0x0008 -> strobes in T1, T2, T3; read data in T4; exactly three strobes.
- Byte write (`HSIZE=0`) to 0x0009:
  - With `AHB2REGBUS_ERR_RESP_EN`: `HRESP=1` for 2 cycles, `HREADYOUT` 0 then 1, no strobe.
  - Without it: OKAY, no strobe.
- IDLE transfer with `HSEL=1` -> `HREADYOUT=1`, `HRESP=0`, no strobe.
- Assert `HRESETn=0` during the RD state -> `HREADYOUT=1`, `HRDATA=0`, `valid_reg_access=0` immediately; the first transfer after release behaves normally.
